// File: rtl/exibicao_pkg.sv
// Shared definitions for the LED display sequencer:
// state codes, default timings and datapath width.
package exibicao_pkg;

    localparam int LARGURA = 4;

    localparam int T_ON_PADRAO      = 1000;
    localparam int T_OFF_PADRAO     = 500;
    localparam int T_ON_FAST_PADRAO = 500;
    localparam int T_OFF_FAST_PADRAO = 250;

    typedef enum logic [3:0] {
        OCIOSO   = 4'd0,
        CARREGA  = 4'd1,
        LEDS_ON  = 4'd2,
        LEDS_OFF = 4'd3,
        FIM      = 4'd4
    } estado_t;

    function automatic int largura_timer(
        input int a,
        input int b,
        input int c,
        input int d
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/temporizador_exibicao.sv
// Loadable down-counter pacing each display phase;
// zero flags the last cycle of the loaded interval.
module temporizador_exibicao #(
    parameter int LARGURA_T = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 carrega,
    input  logic [LARGURA_T-1:0] valor,
    output logic                 zero
);

    logic [LARGURA_T-1:0] contagem;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            contagem <= '0;
        end else if (carrega) begin
            contagem <= valor;
        end else if (contagem != '0) begin
            contagem <= contagem - 1'b1;
        end
    end

    assign zero = (contagem == '0);

endmodule

// File: rtl/sequenciador_exibicao.sv
// Walks the sequence memory from address 0 to the latched
// limit, showing each value for ON cycles then blanking for OFF.
module sequenciador_exibicao
    import exibicao_pkg::*;
#(
    parameter int T_ON       = T_ON_PADRAO,
    parameter int T_OFF      = T_OFF_PADRAO,
    parameter int T_ON_FAST  = T_ON_FAST_PADRAO,
    parameter int T_OFF_FAST = T_OFF_FAST_PADRAO
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         iniciar,
    input  logic         abortar,
    input  logic         nivel,
    input  logic [3:0]   limite,
    input  logic [3:0]   dado_memoria,
    output logic [3:0]   endereco,
    output logic [3:0]   leds,
    output logic         ocupado,
    output logic         fim,
    output logic [3:0]   db_estado
);

    localparam int TW = largura_timer(T_ON, T_OFF, T_ON_FAST, T_OFF_FAST);

    // Counter values are duration-1: zero marks the final cycle.
    localparam logic [TW-1:0] V_CARREGA  = TW'(1);
    localparam logic [TW-1:0] V_ON       = TW'(T_ON - 1);
    localparam logic [TW-1:0] V_OFF      = TW'(T_OFF - 1);
    localparam logic [TW-1:0] V_ON_FAST  = TW'(T_ON_FAST - 1);
    localparam logic [TW-1:0] V_OFF_FAST = TW'(T_OFF_FAST - 1);

    estado_t              estado;
    estado_t              estado_prox;
    logic                 nivel_r;
    logic [LARGURA-1:0]   limite_r;
    logic                 carrega_t;
    logic [TW-1:0]        valor_t;
    logic                 zero_t;
    logic                 cancela;
    logic                 partida;

    assign cancela = abortar && (estado != OCIOSO);
    assign partida = (estado == OCIOSO) && iniciar && !abortar;

    temporizador_exibicao #(
        .LARGURA_T(TW)
    ) u_temporizador (
        .clock  (clock),
        .reset  (reset),
        .carrega(carrega_t),
        .valor  (valor_t),
        .zero   (zero_t)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= estado_prox;
    end

    // Next state and timer reload on every phase entry.
    always_comb begin
        estado_prox = estado;
        carrega_t   = 1'b0;
        valor_t     = '0;
        unique case (estado)
            OCIOSO: begin
                if (partida) begin
                    estado_prox = CARREGA;
                    carrega_t   = 1'b1;
                    valor_t     = V_CARREGA;
                end
            end
            CARREGA: begin
                if (zero_t) begin
                    estado_prox = LEDS_ON;
                    carrega_t   = 1'b1;
                    valor_t     = nivel_r ? V_ON_FAST : V_ON;
                end
            end
            LEDS_ON: begin
                if (zero_t) begin
                    estado_prox = LEDS_OFF;
                    carrega_t   = 1'b1;
                    valor_t     = nivel_r ? V_OFF_FAST : V_OFF;
                end
            end
            LEDS_OFF: begin
                if (zero_t) begin
                    if (endereco == limite_r) begin
                        estado_prox = FIM;
                    end else begin
                        estado_prox = CARREGA;
                        carrega_t   = 1'b1;
                        valor_t     = V_CARREGA;
                    end
                end
            end
            FIM:     estado_prox = OCIOSO;
            default: estado_prox = OCIOSO;
        endcase
        if (cancela) begin
            estado_prox = OCIOSO;
            carrega_t   = 1'b0;
        end
    end

    // Address counter, LED register and start-time latches.
    always_ff @(posedge clock) begin
        if (reset) begin
            endereco <= '0;
            leds     <= '0;
            nivel_r  <= 1'b0;
            limite_r <= '0;
        end else begin
            priority case (1'b1)
                cancela: begin
                    endereco <= '0;
                    leds     <= '0;
                end
                partida: begin
                    nivel_r  <= nivel;
                    limite_r <= limite;
                    endereco <= '0;
                    leds     <= '0;
                end
                (estado == CARREGA) && zero_t:
                    leds <= dado_memoria;
                (estado == LEDS_ON) && zero_t:
                    leds <= '0;
                (estado == LEDS_OFF) && zero_t && (endereco != limite_r):
                    endereco <= endereco + 4'd1;
                (estado == FIM):
                    endereco <= '0;
                default: ;
            endcase
        end
    end

    assign ocupado   = (estado == CARREGA) || (estado == LEDS_ON) ||
                       (estado == LEDS_OFF);
    assign fim       = (estado == FIM);
    assign db_estado = estado;

endmodule

// File: tb/tb_sequenciador_exibicao.sv
// Self-checking bench for sequenciador_exibicao with a 1-cycle
// sync ROM holding 1,2,4,8,... and short timing parameters.
module tb_sequenciador_exibicao;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       abortar;
    logic       nivel;
    logic [3:0] limite;
    logic [3:0] dado_memoria = 4'd0;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       fim;
    logic [3:0] db_estado;

    typedef struct packed {
        logic [3:0] leds;
        logic       fim;
        logic       ocupado;
        logic [3:0] endereco;
        logic [3:0] estado;
    } saida_t;

    typedef struct {
        logic       nivel;
        logic [3:0] limite;
        int         abort_at;
        bit         mexe;
        int         fim_ciclo;
    } caso_t;

    saida_t fila[$];
    caso_t  casos[8];
    int     checks = 0;
    int     erros  = 0;

    sequenciador_exibicao #(
        .T_ON      (4),
        .T_OFF     (2),
        .T_ON_FAST (2),
        .T_OFF_FAST(1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .abortar     (abortar),
        .nivel       (nivel),
        .limite      (limite),
        .dado_memoria(dado_memoria),
        .endereco    (endereco),
        .leds        (leds),
        .ocupado     (ocupado),
        .fim         (fim),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] padrao(input int a);
        logic [3:0] p;
        p = 4'b0001 << (a % 4);
        return p;
    endfunction

    always @(posedge clock) dado_memoria <= padrao(int'(endereco));

    function automatic saida_t lida();
        saida_t s;
        s = {leds, fim, ocupado, endereco, db_estado};
        return s;
    endfunction

    // Expected outputs in cycle c, from the published timing.
    function automatic saida_t esperado(input int c, input logic nv,
                                        input int l, input int ab);
        int ton, toff, per, total, e, off;
        saida_t s;
        s = '0;
        if (ab > 0 && c > ab) return s;
        ton   = nv ? 2 : 4;
        toff  = nv ? 1 : 2;
        per   = 2 + ton + toff;
        total = (l + 1) * per;
        if (c <= total) begin
            e          = (c - 1) / per;
            off        = (c - 1) % per;
            s.ocupado  = 1'b1;
            s.endereco = 4'(e);
            if (off < 2) begin
                s.estado = 4'd1;
            end else if (off < 2 + ton) begin
                s.estado = 4'd2;
                s.leds   = padrao(e);
            end else begin
                s.estado = 4'd3;
            end
        end else if (c == total + 1) begin
            s.fim      = 1'b1;
            s.endereco = 4'(l);
            s.estado   = 4'd4;
        end
        return s;
    endfunction

    task automatic compara(input string nome, input int ciclo,
                           input saida_t got, input saida_t exp);
        checks++;
        if (got !== exp) begin
            erros++;
            $display("FAIL %s cycle %0d: got leds=%h fim=%b ocup=%b end=%h est=%h, expected leds=%h fim=%b ocup=%b end=%h est=%h",
                     nome, ciclo, got.leds, got.fim, got.ocupado,
                     got.endereco, got.estado, exp.leds, exp.fim,
                     exp.ocupado, exp.endereco, exp.estado);
        end
    endtask

    task automatic compara_int(input string nome, input int got,
                               input int exp);
        checks++;
        if (got != exp) begin
            erros++;
            $display("FAIL %s: got %0d, expected %0d", nome, got, exp);
        end
    endtask

    task automatic roda(input int k);
        caso_t  cs;
        int     n, fim_visto;
        saida_t exp;
        cs = casos[k];
        n  = (cs.abort_at > 0) ? cs.abort_at + 20 :
             (cs.limite + 1) * (cs.nivel ? 5 : 8) + 4;
        for (int c = 1; c <= n; c++)
            fila.push_back(esperado(c, cs.nivel, int'(cs.limite),
                                    cs.abort_at));
        @(negedge clock);
        nivel   = cs.nivel;
        limite  = cs.limite;
        iniciar = 1'b1;
        fim_visto = -1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            exp = fila.pop_front();
            compara($sformatf("caso%0d", k), c, lida(), exp);
            if (fim && fim_visto < 0) fim_visto = c;
            iniciar = cs.mexe && (c == 10);
            abortar = (cs.abort_at > 0) && (c == cs.abort_at);
            if (cs.mexe && c == 12) begin
                nivel  = 1'b1;
                limite = 4'd5;
            end
        end
        compara_int($sformatf("caso%0d_fim_ciclo", k), fim_visto,
                    cs.fim_ciclo);
    endtask

    initial begin
        casos[0] = '{nivel: 1'b0, limite: 4'd2,  abort_at: 0,  mexe: 1'b0, fim_ciclo: 25};
        casos[1] = '{nivel: 1'b1, limite: 4'd0,  abort_at: 0,  mexe: 1'b0, fim_ciclo: 6};
        casos[2] = '{nivel: 1'b0, limite: 4'd2,  abort_at: 12, mexe: 1'b0, fim_ciclo: -1};
        casos[3] = '{nivel: 1'b0, limite: 4'd0,  abort_at: 0,  mexe: 1'b0, fim_ciclo: 9};
        casos[4] = '{nivel: 1'b0, limite: 4'd2,  abort_at: 0,  mexe: 1'b1, fim_ciclo: 25};
        casos[5] = '{nivel: 1'b0, limite: 4'd15, abort_at: 0,  mexe: 1'b0, fim_ciclo: 129};
        casos[6] = '{nivel: 1'b1, limite: 4'd3,  abort_at: 0,  mexe: 1'b0, fim_ciclo: 21};
        casos[7] = '{nivel: 1'b1, limite: 4'd15, abort_at: 0,  mexe: 1'b0, fim_ciclo: 81};

        reset   = 1'b1;
        iniciar = 1'b0;
        abortar = 1'b0;
        nivel   = 1'b0;
        limite  = 4'd0;
        repeat (2) @(negedge clock);
        compara("reset_inicial", 0, lida(), '0);
        reset = 1'b0;

        // abortar wins over iniciar while idle
        @(negedge clock);
        iniciar = 1'b1;
        abortar = 1'b1;
        @(negedge clock);
        compara("iniciar_e_abortar", 1, lida(), '0);
        iniciar = 1'b0;
        abortar = 1'b0;

        for (int k = 0; k < 8; k++) roda(k);

        // reset asserted mid-show
        @(negedge clock);
        nivel   = 1'b0;
        limite  = 4'd2;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (4) @(negedge clock);
        compara("antes_reset", 5, lida(),
                esperado(5, 1'b0, 2, 0));
        reset = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clock);
            compara("reset_meio", i, lida(), '0);
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        compara("pos_reset", 3, lida(), '0);

        roda(0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, erros);
        $finish;
    end

endmodule

// File: doc/sequenciador_exibicao.md
# sequenciador_exibicao

Controller that sequences the LED display phase of the memory game. On a start pulse it walks the sequence memory from address 0 to a latched limit, shows each stored value on the LEDs for a level-dependent ON time, blanks them for an OFF time, then signals completion. It sits between the game control unit, which issues `iniciar`/`abortar` and waits for `fim`, and the sequence memory plus LED outputs of the datapath.

## Interface

**Parameters**
- `T_ON`, default 1000: LED-on cycles per element, normal level.
- `T_OFF`, default 500: LED-off cycles per element, normal level.
- `T_ON_FAST`, default 500: LED-on cycles, fast level.
- `T_OFF_FAST`, default 250: LED-off cycles, fast level.
- All four parameters must be ≥ 1.

**Ports** (`name direction width meaning`)
- `clock` input 1: single clock; everything is rising-edge.
- `reset` input 1: synchronous, active-high.
- `iniciar` input 1: start request, sampled only in OCIOSO.
- `abortar` input 1: cancel request, any state.
- `nivel` input 1: 0 selects normal timing, 1 selects fast timing; latched at start.
- `limite` input 4: last address to display; latched at start.
- `dado_memoria` input 4: sequence memory read data.
- `endereco` output 4: sequence memory address (registered).
- `leds` output 4: LED drive (registered).
- `ocupado` output 1: high while a show is in progress.
- `fim` output 1: one-cycle completion pulse.
- `db_estado` output 4: state code for the 7-segment debug display.

## Operation

**States and `db_estado` codes:** OCIOSO=0, CARREGA=1, LEDS_ON=2, LEDS_OFF=3, FIM=4.

- **Reset.** State OCIOSO; `endereco`=0, `leds`=0, `ocupado`=0, `fim`=0, `db_estado`=0.
- **OCIOSO.**
  - `iniciar`=1 and `abortar`=0: latch `nivel` and `limite`, set `endereco`=0, go to CARREGA.
  - Otherwise stay in OCIOSO.
  - `endereco` and `leds` are held at 0.
- **CARREGA.**
  - Lasts exactly 2 cycles.
  - `dado_memoria` is captured into `leds` at the final edge, so a synchronous-read memory with 1-cycle latency is supported.
  - Next state: LEDS_ON.
- **LEDS_ON.**
  - `leds` holds the captured value for T_ON cycles, or T_ON_FAST cycles when the latched `nivel` is 1.
  - Next state: LEDS_OFF, with `leds`=0.
- **LEDS_OFF.**
  - Lasts T_OFF cycles, or T_OFF_FAST when fast.
  - At the last cycle: if `endereco` equals the latched `limite`, go to FIM.
  - Otherwise increment `endereco` and go to CARREGA.
- **FIM.**
  - Lasts 1 cycle with `fim`=1.
  - Next state: OCIOSO, where `endereco` returns to 0.
- **`ocupado`.** High in CARREGA, LEDS_ON and LEDS_OFF. Low in OCIOSO and FIM.

**Boundary rules**
- `abortar`=1 in any non-OCIOSO state: next cycle is OCIOSO with `leds`=0 and `endereco`=0, and no `fim` pulse. `abortar` wins over `iniciar`.
- `iniciar` while not in OCIOSO is ignored, including during FIM.
- Changes to `nivel` or `limite` mid-show are ignored.
- `limite`=15 displays all 16 addresses. `endereco` never wraps inside a show; the comparison to `limite` terminates it first.
- `limite`=0 displays only address 0.
- A 4-bit `dado_memoria` of 0 is displayed as blank LEDs for the ON time; there is no special handling.

## Timing

- Take the edge that samples `iniciar` as edge 0.
- CARREGA occupies cycles 1–2.
- Per element: 2 + ton + toff cycles, where ton/toff are the active level's values.
- `fim` is high in cycle 1 + (L+1)·(2+ton+toff), where L is the latched `limite`.
- `leds` changes only at state-transition edges; there are no glitches.
- Worst-case timer width: $clog2 of max(T_ON, T_OFF, T_ON_FAST, T_OFF_FAST) + 1.

## Structure

- **Shared package `exibicao_pkg`:**
  - State encoding constants (the `db_estado` codes above).
  - Default timing constants.
  - Address/data width constant, value 4.
- **Sub-module `temporizador_exibicao`:**
  - Loadable down-counter with `carrega`, `valor` and `zero` signals.
  - Reloaded on entry to LEDS_ON and LEDS_OFF.
  - Also reused for the 2-cycle CARREGA wait.
- The FSM, address counter, and latched `nivel`/`limite` registers live in the top module.

## Test plan

Bench parameters: T_ON=4, T_OFF=2, T_ON_FAST=2, T_OFF_FAST=1. The memory model is a sync ROM with contents 1, 2, 4, 8, 1, 2, … and 1-cycle latency.

- **Reset:** assert `reset` for 2 cycles mid-show → all outputs 0, `db_estado`=0, `endereco`=0 on the next cycle.
- **Normal level:** `nivel`=0, `limite`=2, `iniciar` pulse at edge 0 →
  - `leds`=1 in cycles 3–6, 0 in cycles 7–8;
  - `leds`=2 in cycles 11–14; `leds`=4 in cycles 19–22;
  - `fim` in cycle 25 only; `ocupado` high in cycles 1–24.
- **Fast level:** `nivel`=1, `limite`=0 → `leds`=1 in cycles 3–4, 0 in cycle 5, `fim` in cycle 6.
- **Abort:** `abortar` pulse during the LEDS_ON of element 1 → next cycle OCIOSO with `leds`=0 and `endereco`=0; `fim` never asserts; a new `iniciar` restarts from address 0.
- **Ignored inputs mid-show:** with `limite`=2, pulse `iniciar` in cycle 10, toggle `nivel` to 1 in cycle 12, and change `limite` to 5 → `fim` still in cycle 25 and the LED pattern matches the normal-level case.
- **Full sequence:** `limite`=15, `nivel`=0 → `endereco` steps 0..15 without wrap, `fim` in cycle 129, then `endereco`=0.
